// File: rtl/audio_mix_mac_if.sv
// Mixer bus: strobe and packed channel/volume inputs towards the mixer,
// mixed sample and status back towards the consumer (compressor side).
// Optional AUDIO_MIX_CLIP_CNT_EN adds clip_cnt / clip_clr.
interface audio_mix_mac_if #(
  parameter int NCH  = 4,
  parameter int IN_W = 10
);
  logic                  ce_sample;
  logic [NCH*IN_W-1:0]   ch_in;
  logic [NCH*4-1:0]      vol;
  logic [9:0]            dout;
  logic                  dout_valid;
  logic                  busy;
  logic                  overrun;
`ifdef AUDIO_MIX_CLIP_CNT_EN
  logic [7:0]            clip_cnt;
  logic                  clip_clr;

  modport master (
    output ce_sample, ch_in, vol, clip_clr,
    input  dout, dout_valid, busy, overrun, clip_cnt
  );

  modport slave (
    input  ce_sample, ch_in, vol, clip_clr,
    output dout, dout_valid, busy, overrun, clip_cnt
  );
`else
  modport master (
    output ce_sample, ch_in, vol,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  ce_sample, ch_in, vol,
    output dout, dout_valid, busy, overrun
  );
`endif
endinterface

// File: rtl/audio_mix_mac.sv
// audio_mix_mac: time-multiplexed multiply-accumulate mixer.
// One shared multiplier, one channel per clock. Sum of sample*volume is
// arithmetically shifted right by SHIFT and clamped to a 10-bit signed
// sample that feeds the downstream compressor.
// Optional feature macro: AUDIO_MIX_CLIP_CNT_EN (saturating clip counter).
module audio_mix_mac #(
  parameter int NCH   = 4,
  parameter int IN_W  = 10,
  parameter int SHIFT = 4
) (
  input  logic            clk,
  input  logic            reset,
  audio_mix_mac_if.slave  bus
);

  localparam int P_W   = IN_W + 5;
  localparam int A_W   = IN_W + 5 + $clog2(NCH) + 1;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NCH - 1);
  localparam logic signed [A_W-1:0] SAT_MAX  = A_W'(511);
  localparam logic signed [A_W-1:0] SAT_MIN  = A_W'(-512);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_SAT,
    S_DONE
  } state_t;

  state_t                  state;
  logic signed [IN_W-1:0]  samp_q [NCH];
  logic [3:0]              vol_q  [NCH];
  logic signed [A_W-1:0]   acc;
  logic [IDX_W-1:0]        idx;
  logic [9:0]              res_q;
  logic [9:0]              dout_q;
  logic                    dout_valid_q;
  logic                    busy_q;
  logic                    overrun_q;

  logic signed [P_W-1:0]   samp_ext;
  logic signed [P_W-1:0]   vol_ext;
  logic signed [P_W-1:0]   prod;
  logic signed [A_W-1:0]   shifted;
  logic                    clip_hi;
  logic                    clip_lo;
  logic [9:0]              sat_val;

  // Shared multiplier: current channel sample times zero-extended volume
  always_comb begin
    samp_ext = P_W'(samp_q[idx]);
    vol_ext  = P_W'({1'b0, vol_q[idx]});
    prod     = samp_ext * vol_ext;
  end

  // Scale the accumulated sum and clamp it to the 10-bit signed range
  always_comb begin
    shifted = acc >>> SHIFT;
    clip_hi = (shifted > SAT_MAX);
    clip_lo = (shifted < SAT_MIN);
    sat_val = shifted[9:0];
    if (clip_hi) begin
      sat_val = 10'h1FF;
    end else if (clip_lo) begin
      sat_val = 10'h200;
    end
  end

  // Mix sequencer: load, accumulate NCH channels, saturate, publish.
  // The clamped value is parked in res_q during SAT and copied to dout on
  // leaving DONE so that dout and dout_valid change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      acc          <= '0;
      idx          <= '0;
      res_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        samp_q[k] <= '0;
        vol_q[k]  <= '0;
      end
    end else begin
      dout_valid_q <= 1'b0;
      overrun_q    <= bus.ce_sample && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.ce_sample) begin
            state  <= S_LOAD;
            busy_q <= 1'b1;
          end
        end
        S_LOAD: begin
          for (int unsigned k = 0; k < NCH; k++) begin
            samp_q[k] <= bus.ch_in[k*IN_W +: IN_W];
            vol_q[k]  <= bus.vol[k*4 +: 4];
          end
          acc   <= '0;
          idx   <= '0;
          state <= S_ACC;
        end
        S_ACC: begin
          acc <= acc + A_W'(prod);
          if (idx == LAST_IDX) begin
            state <= S_SAT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_SAT: begin
          res_q <= sat_val;
          state <= S_DONE;
        end
        S_DONE: begin
          dout_q       <= res_q;
          dout_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

`ifdef AUDIO_MIX_CLIP_CNT_EN
  logic [7:0] clip_cnt_q;

  // Saturating count of clamped samples; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_cnt_q <= '0;
    end else if (bus.clip_clr) begin
      clip_cnt_q <= '0;
    end else if ((state == S_SAT) && (clip_hi || clip_lo) && (clip_cnt_q != 8'hFF)) begin
      clip_cnt_q <= clip_cnt_q + 8'd1;
    end
  end

  assign bus.clip_cnt = clip_cnt_q;
`endif

endmodule
